// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types and constants: fetch FSM states and the IF/ID payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Empty slot: a NOP bubble at pc 0, so pc_plus4 stays consistent with pc.
  localparam if_id_t IF_ID_RESET = '{
    instr:    NOP_INSTR,
    pc:       XLEN'(0),
    pc_plus4: XLEN'(4),
    valid:    1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// One IF/ID slot with flush > hold > load priority; also used as the stall hold buffer.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   hold_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;
  if_id_t q_d;

  // Flush turns the slot into a bubble but keeps its pc fields; idle slot keeps its value.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.instr = NOP_INSTR;
      q_d.valid = 1'b0;
    end else if (hold_i) begin
      q_d = q_q;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  // Slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= IF_ID_RESET;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request, stall hold buffer, redirect flush.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned      Width   = 32,
  parameter logic [Width-1:0] ResetPC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic [Width-1:0] imem_rdata,
  input  logic             imem_ready,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [Width-1:0] redirect_pc_i,
  output logic [Width-1:0] id_instr,
  output logic [Width-1:0] id_pc,
  output logic [Width-1:0] id_pc_plus4,
  output logic             id_valid
);

  fetch_state_t     state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic             imem_req_q, imem_req_d;

  logic [Width-1:0] pc_plus4;
  logic             beat;
  if_id_t           fetched;
  if_id_t           id_d;
  if_id_t           id_q;
  if_id_t           buf_q;
  logic             id_flush, id_hold, id_load;
  logic             buf_flush, buf_hold, buf_load;

  assign beat     = imem_req_q && imem_ready;
  assign pc_plus4 = pc_q + Width'(4);
  assign fetched  = '{
    instr:    XLEN'(imem_rdata),
    pc:       XLEN'(pc_q),
    pc_plus4: XLEN'(pc_plus4),
    valid:    1'b1
  };

  // Next state, next PC and slot controls; a redirect overrides stall and any beat.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_d       = fetched;
    id_flush   = 1'b0;
    id_hold    = 1'b0;
    id_load    = 1'b0;
    buf_flush  = 1'b0;
    buf_hold   = 1'b0;
    buf_load   = 1'b0;
    imem_req_d = 1'b0;

    if (redirect_i) begin
      state_d   = FETCH;
      pc_d      = redirect_pc_i & ~Width'(3);
      id_flush  = 1'b1;
      buf_flush = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          id_hold = stall_i;
          state_d = FETCH;
        end
        FETCH: begin
          id_hold = stall_i;
          if (beat) begin
            pc_d = pc_plus4;
            if (stall_i) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              id_load = 1'b1;
            end
          end else if (!stall_i) begin
            id_flush = 1'b1;
          end
        end
        HOLD: begin
          id_hold  = stall_i;
          buf_hold = stall_i;
          if (!stall_i) begin
            id_d      = buf_q;
            id_load   = 1'b1;
            buf_flush = 1'b1;
            state_d   = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    imem_req_d = (state_d == FETCH);
  end

  // State, PC and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= ResetPC;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= imem_req_d;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (id_flush),
    .hold_i  (id_hold),
    .load_i  (id_load),
    .d_i     (id_d),
    .q_o     (id_q)
  );

  if_id_reg u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (buf_flush),
    .hold_i  (buf_hold),
    .load_i  (buf_load),
    .d_i     (fetched),
    .q_o     (buf_q)
  );

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign id_instr    = Width'(id_q.instr);
  assign id_pc       = Width'(id_q.pc);
  assign id_pc_plus4 = Width'(id_q.pc_plus4);
  assign id_valid    = id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model of the fetch pipe.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_valid;

  logic [31:0] key;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  // Memory returns a keyed function of the address (key 0 gives data = address).
  assign imem_rdata = imem_addr ^ key;

  fetch_stage #(.Width(32), .ResetPC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_valid      (id_valid)
  );

  fetch_stage #(.Width(32), .ResetPC(32'hFFFF_FFFC)) dut_w (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_rdata    (w_addr),
    .imem_ready    (1'b1),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0000_0000),
    .id_instr      (w_instr),
    .id_pc         (w_pc),
    .id_pc_plus4   (w_pc4),
    .id_valid      (w_valid)
  );

  // Reference model: phase 0 = idle, 1 = fetching, 2 = parked word waiting for decode.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ent_t;

  int          m_phase;
  logic [31:0] m_pc;
  ent_t        m_id;
  ent_t        m_buf[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset(input logic [31:0] rpc);
    m_phase = 0;
    m_pc    = rpc;
    m_buf.delete();
    m_id    = '{instr: 32'h0000_0013, pc: 32'h0, valid: 1'b0};
  endtask

  task automatic compare_all();
    check("imem_req", 32'(imem_req), 32'(m_phase == 1));
    if (m_phase == 1) check("imem_addr", imem_addr, m_pc);
    check("id_valid", 32'(id_valid), 32'(m_id.valid));
    check("id_instr", id_instr, m_id.instr);
    check("id_pc", id_pc, m_id.pc);
    check("id_pc_plus4", id_pc_plus4, m_id.pc + 32'd4);
  endtask

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic step();
    bit   beat;
    ent_t w;
    beat = (m_phase == 1) && imem_ready;
    w    = '{instr: m_pc ^ key, pc: m_pc, valid: 1'b1};
    if (redirect_i) begin
      m_pc = {redirect_pc_i[31:2], 2'b00};
      m_buf.delete();
      m_phase = 1;
      m_id.valid = 1'b0;
      m_id.instr = 32'h0000_0013;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (beat) begin
        m_pc = m_pc + 32'd4;
        if (stall_i) begin
          m_buf.push_back(w);
          m_phase = 2;
        end else begin
          m_id = w;
        end
      end else if (!stall_i) begin
        m_id.valid = 1'b0;
        m_id.instr = 32'h0000_0013;
      end
    end else if (!stall_i) begin
      m_id = m_buf.pop_front();
      m_phase = 1;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc);
    imem_ready    = rdy;
    stall_i       = stl;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
  endtask

  initial begin
    key = 32'h0;
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc4", id_pc_plus4, 32'h4);

    // Streaming from reset, data = address.
    rst_n = 1'b1;
    m_reset(32'h0);
    step();
    check("first_req_addr", imem_addr, 32'h0);
    step();
    check("wrap_id_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_id_pc4", w_pc4, 32'h0);
    check("wrap_next_addr", w_addr, 32'h0);
    check("wrap_valid", 32'(w_valid), 32'h1);
    step();
    check("stream_pc4", id_pc, 32'h4);

    // Three wait states at pc 8.
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      step();
      check("wait_addr", imem_addr, 32'h8);
      check("wait_bubble", 32'(id_valid), 32'h0);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("after_wait_pc", id_pc, 32'h8);

    // Two-cycle decode stall during the beat at pc 12.
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("stall_keep_pc", id_pc, 32'h8);
    check("hold_no_req", 32'(imem_req), 32'h0);
    step();
    check("hold_no_req2", 32'(imem_req), 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("release_pc", id_pc, 32'hC);
    check("release_next_addr", imem_addr, 32'h10);

    // Redirect while parked in HOLD.
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    set_in(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    step();
    check("redir_flush", 32'(id_valid), 32'h0);
    check("redir_addr", imem_addr, 32'h0000_0100);
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("redir_id_pc", id_pc, 32'h0000_0100);

    // Random traffic.
    key = $urandom;
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 11) == 0), $urandom);
      step();
    end

    // Asynchronous reset between edges while parked in HOLD.
    set_in(1'b1, 1'b0, 1'b1, 32'h0000_4000);
    step();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("pre_arst_hold", 32'(imem_req), 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_valid", 32'(id_valid), 32'h0);
    check("arst_instr", id_instr, 32'h0000_0013);
    check("arst_pc", id_pc, 32'h0);
    check("arst_pc4", id_pc_plus4, 32'h4);
    check("arst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset(32'h0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("restart_addr", imem_addr, 32'h0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
